ethernet_rx_framer: RTL

Receive-side front end for each hub port. It sits between the PHY byte interface and the frame parser. It strips the preamble and SFD, delimits the frame with sof/eof markers, and runs a CRC-32 check over every byte after the SFD. It also enforces frame-length limits and reports good or bad status with the last byte, so the parser and forwarding logic receive clean, aligned frames.

---
 rtl/ethernet_rx_framer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_rx_framer.sv
// Ethernet receive framer: strips preamble/SFD, delimits the frame with
// sof/eof, checks CRC-32 over every post-SFD byte (FCS included) and the
// frame length, and reports status on the last byte.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   rx_data, rx_valid    PHY byte stream, rx_valid contiguous per frame
//   frm_data, frm_valid  post-SFD frame bytes, one cycle behind the hold stage
//   frm_sof, frm_eof     first / last byte markers (qualified by frm_valid)
//   frm_good, frm_crc_err, frm_len_err   status, only non-zero with frm_eof
//   drop_count           saturating count of bad preambles and empty frames
module ethernet_rx_framer #(
  parameter int unsigned PRE_MIN = 7,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  frm_data,
  output logic        frm_valid,
  output logic        frm_sof,
  output logic        frm_eof,
  output logic        frm_good,
  output logic        frm_crc_err,
  output logic        frm_len_err,
  output logic [15:0] drop_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PRE_W  = 4;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned CRC_W  = 32;
  localparam int unsigned DROP_W = 16;

  localparam logic [BYTE_W-1:0] PRE_BYTE    = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE    = 8'hD5;
  localparam logic [CRC_W-1:0]  CRC_POLY    = 32'hEDB88320;
  localparam logic [CRC_W-1:0]  CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0]  CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic               hold_sof_q, hold_sof_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               drop_inc;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               good_q, good_d;
  logic               crc_err_q, crc_err_d;
  logic               len_err_q, len_err_d;
  logic               crc_bad, len_bad;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] crc,
                                                input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Frame status as seen at the eof beat: counter already includes the last byte.
  always_comb begin
    crc_bad = (crc_q != CRC_RESIDUE);
    len_bad = (32'(cnt_q) < MIN_LEN) || (32'(cnt_q) > MAX_LEN);
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    hold_sof_d = hold_sof_q;
    drop_d     = drop_q;
    drop_inc   = 1'b0;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    good_d     = 1'b0;
    crc_err_d  = 1'b0;
    len_err_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == PRE_BYTE) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d  = S_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!rx_valid) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end else if (rx_data == PRE_BYTE) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((rx_data == SFD_BYTE) && (32'(pre_cnt_q) >= PRE_MIN)) begin
          state_d    = S_DATA;
          crc_d      = CRC_INIT;
          cnt_d      = '0;
          hold_vld_d = 1'b0;
        end else begin
          state_d  = S_DROP;
          drop_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          // Previous byte leaves the hold stage as a mid-frame beat.
          if (hold_vld_q) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            sof_d   = hold_sof_q;
          end
          crc_d      = crc_next(crc_q, rx_data);
          cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
          hold_d     = rx_data;
          hold_vld_d = 1'b1;
          hold_sof_d = (cnt_q == '0);
        end else begin
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            data_d    = hold_q;
            valid_d   = 1'b1;
            sof_d     = hold_sof_q;
            eof_d     = 1'b1;
            crc_err_d = crc_bad;
            len_err_d = len_bad;
            good_d    = !crc_bad && !len_bad;
          end else begin
            // SFD with nothing behind it.
            drop_inc = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!rx_valid) state_d = S_IDLE;
      end
      default: state_d = S_DROP;
    endcase

    if (drop_inc && (drop_q != '1)) drop_d = drop_q + 16'd1;
  end

  // State and output registers; reset parks in DROP so a cut frame is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_DROP;
      pre_cnt_q  <= '0;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      hold_sof_q <= 1'b0;
      drop_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      good_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      hold_sof_q <= hold_sof_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      good_q     <= good_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
    end
  end

  assign frm_data    = data_q;
  assign frm_valid   = valid_q;
  assign frm_sof     = sof_q;
  assign frm_eof     = eof_q;
  assign frm_good    = good_q;
  assign frm_crc_err = crc_err_q;
  assign frm_len_err = len_err_q;
  assign drop_count  = drop_q;

endmodule
